// File: rtl/song_pkg.sv
// Shared definitions for the song sequencer: entry field layout and FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package song_pkg;

  localparam int ENTRY_W     = 16;
  localparam int IS_WAIT_BIT = 15;
  localparam int NOTE_MSB    = 14;
  localparam int NOTE_LSB    = 9;
  localparam int DUR_MSB     = 8;
  localparam int DUR_LSB     = 3;
  localparam int META_MSB    = 2;
  localparam int META_LSB    = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_WAIT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/song_reader_voice_alloc.sv
// Voice allocator: picks the lowest free voice, otherwise steals round-robin.
// Latency: grant is combinational; the steal pointer updates on the next edge.
// Backpressure: none, a grant is always produced (stealing when all are busy).
module voice_alloc #(
  parameter int NUM_VOICES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_VOICES-1:0] voice_busy,
  input  logic                  alloc,
  output logic [NUM_VOICES-1:0] grant
);

  localparam int PTR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             found;

  // Lowest-index free voice wins; with no free voice the steal pointer chooses.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!voice_busy[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    if (!found) begin
      grant[rr_ptr_q] = 1'b1;
    end
  end

  // The steal pointer only moves when a steal actually happens.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (alloc && !found) begin
      rr_ptr_d = (rr_ptr_q == PTR_W'(NUM_VOICES - 1)) ? '0 : rr_ptr_q + 1'b1;
    end
  end

  // Steal pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/song_reader.sv
// Song sequencer: walks ROM entries, dispatches notes to voices, stalls on wait entries.
// Latency: 2 cycles per note or zero-wait entry; waits add N beats.
// Backpressure: play=0 pauses fetch/decode/wait; a busy voice set is stolen, never stalls.
module song_reader
  import song_pkg::*;
#(
  parameter int NUM_VOICES = 3,
  parameter int SONG_BITS  = 2,
  parameter int IDX_BITS   = 5,
  parameter int NOTE_W     = 6,
  parameter int DUR_W      = 6,
  parameter int META_W     = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          play,
  input  logic [SONG_BITS-1:0]          song,
  input  logic                          beat,
  input  logic [NUM_VOICES-1:0]         voice_busy,
  output logic [SONG_BITS+IDX_BITS-1:0] rom_addr,
  input  logic [ENTRY_W-1:0]            rom_dout,
  output logic [NUM_VOICES-1:0]         note_load,
  output logic [NOTE_W-1:0]             note_out,
  output logic [DUR_W-1:0]              duration_out,
  output logic [META_W-1:0]             meta_out,
  output logic                          song_done
);

  state_e                state_q, state_d;
  logic [SONG_BITS-1:0]  song_reg_q, song_reg_d;
  logic [IDX_BITS-1:0]   idx_q, idx_d;
  logic [DUR_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic [NUM_VOICES-1:0] note_load_q, note_load_d;
  logic [NOTE_W-1:0]     note_out_q, note_out_d;
  logic [DUR_W-1:0]      duration_out_q, duration_out_d;
  logic [META_W-1:0]     meta_out_q, meta_out_d;
  logic                  song_done_q, song_done_d;

  logic                  alloc;
  logic [NUM_VOICES-1:0] grant;
  logic                  restart;
  logic                  advance;
  logic                  song_chg;

  logic                  ent_wait;
  logic [NOTE_W-1:0]     ent_note;
  logic [DUR_W-1:0]      ent_dur;
  logic [META_W-1:0]     ent_meta;

  assign ent_wait = rom_dout[IS_WAIT_BIT];
  assign ent_note = rom_dout[NOTE_MSB:NOTE_LSB];
  assign ent_dur  = rom_dout[DUR_MSB:DUR_LSB];
  assign ent_meta = rom_dout[META_MSB:META_LSB];

  assign rom_addr     = {song_reg_q, idx_q};
  assign note_load    = note_load_q;
  assign note_out     = note_out_q;
  assign duration_out = duration_out_q;
  assign meta_out     = meta_out_q;
  assign song_done    = song_done_q;

  voice_alloc #(
    .NUM_VOICES(NUM_VOICES)
  ) u_voice_alloc (
    .clk       (clk),
    .reset     (reset),
    .voice_busy(voice_busy),
    .alloc     (alloc),
    .grant     (grant)
  );

  // Next-state logic; a song change overrides beat and dispatch in every active state.
  always_comb begin
    state_d        = state_q;
    song_reg_d     = song_reg_q;
    idx_d          = idx_q;
    wait_cnt_d     = wait_cnt_q;
    note_load_d    = '0;
    note_out_d     = note_out_q;
    duration_out_d = duration_out_q;
    meta_out_d     = meta_out_q;
    song_done_d    = 1'b0;
    alloc          = 1'b0;
    restart        = 1'b0;
    advance        = 1'b0;
    song_chg       = (song != song_reg_q);

    case (state_q)
      ST_IDLE: begin
        if (play) begin
          song_reg_d = song;
          idx_d      = '0;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (song_chg)  restart = 1'b1;
        else if (play) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (song_chg) begin
          restart = 1'b1;
        end else if (play) begin
          if (!ent_wait) begin
            alloc          = 1'b1;
            note_load_d    = grant;
            note_out_d     = ent_note;
            duration_out_d = ent_dur;
            meta_out_d     = ent_meta;
            advance        = 1'b1;
          end else if (ent_dur == '0) begin
            advance = 1'b1;
          end else begin
            wait_cnt_d = ent_dur;
            state_d    = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (song_chg) begin
          restart = 1'b1;
        end else if (beat && play) begin
          wait_cnt_d = wait_cnt_q - 1'b1;
          if (wait_cnt_q == DUR_W'(1)) advance = 1'b1;
        end
      end
      ST_DONE: begin
        if (song_chg)   restart = 1'b1;
        else if (!play) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (restart) begin
      song_reg_d = song;
      idx_d      = '0;
      state_d    = ST_FETCH;
    end

    // The last entry of a song ends in DONE rather than wrapping to entry 0.
    if (advance) begin
      if (idx_q == '1) begin
        state_d     = ST_DONE;
        song_done_d = 1'b1;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = ST_FETCH;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      song_reg_q     <= '0;
      idx_q          <= '0;
      wait_cnt_q     <= '0;
      note_load_q    <= '0;
      note_out_q     <= '0;
      duration_out_q <= '0;
      meta_out_q     <= '0;
      song_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      song_reg_q     <= song_reg_d;
      idx_q          <= idx_d;
      wait_cnt_q     <= wait_cnt_d;
      note_load_q    <= note_load_d;
      note_out_q     <= note_out_d;
      duration_out_q <= duration_out_d;
      meta_out_q     <= meta_out_d;
      song_done_q    <= song_done_d;
    end
  end

endmodule

// File: tb/tb_song_reader.sv
// Bench for song_reader: directed scenarios with literal expectations, then random traffic
// checked every cycle against a behavioural model of the sequencer.
module tb_song_reader;

  localparam int NV = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        play = 1'b0;
  logic [1:0]  song = 2'd0;
  logic        beat = 1'b0;
  logic [2:0]  voice_busy = 3'b000;
  logic [6:0]  rom_addr;
  logic [15:0] rom_dout = 16'h0000;
  logic [2:0]  note_load;
  logic [5:0]  note_out;
  logic [5:0]  duration_out;
  logic [2:0]  meta_out;
  logic        song_done;

  logic [15:0] rom [128];

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  // Behavioural model state: 0 idle, 1 fetch, 2 decode, 3 wait, 4 done.
  int m_phase, m_sreg, m_idx, m_beats, m_rr;
  logic [6:0] e_addr;
  logic [2:0] e_load;
  logic [5:0] e_note, e_dur;
  logic [2:0] e_meta;
  logic       e_done;

  song_reader dut (
    .clk         (clk),
    .reset       (reset),
    .play        (play),
    .song        (song),
    .beat        (beat),
    .voice_busy  (voice_busy),
    .rom_addr    (rom_addr),
    .rom_dout    (rom_dout),
    .note_load   (note_load),
    .note_out    (note_out),
    .duration_out(duration_out),
    .meta_out    (meta_out),
    .song_done   (song_done)
  );

  always #5 clk = ~clk;

  // Registered ROM: data appears one cycle after the address.
  always @(posedge clk) rom_dout <= rom[rom_addr];

  function automatic logic [15:0] note_ent(input int n, input int d, input int m);
    return {1'b0, 6'(n), 6'(d), 3'(m)};
  endfunction

  function automatic logic [15:0] wait_ent(input int d);
    return {1'b1, 6'd0, 6'(d), 3'd0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic next_entry();
    if (m_idx == 31) begin
      m_phase = 4;
      e_done  = 1'b1;
    end else begin
      m_idx++;
      m_phase = 1;
    end
  endtask

  // One clock of the sequencer as described: uses only bench inputs and ROM contents.
  task automatic model_update();
    logic [15:0] ent;
    int v;
    e_load = 3'b000;
    e_done = 1'b0;
    if (reset) begin
      m_phase = 0; m_sreg = 0; m_idx = 0; m_beats = 0; m_rr = 0;
      e_note = 0; e_dur = 0; e_meta = 0;
    end else if (m_phase != 0 && int'(song) != m_sreg) begin
      m_sreg = int'(song); m_idx = 0; m_phase = 1;
    end else begin
      case (m_phase)
        0: if (play) begin m_sreg = int'(song); m_idx = 0; m_phase = 1; end
        1: if (play) m_phase = 2;
        2: if (play) begin
          ent = rom[m_sreg * 32 + m_idx];
          if (!ent[15]) begin
            v = -1;
            for (int i = 0; i < NV; i++) if (!voice_busy[i] && v < 0) v = i;
            if (v < 0) begin v = m_rr; m_rr = (m_rr + 1) % NV; end
            e_load = 3'(1 << v);
            e_note = ent[14:9]; e_dur = ent[8:3]; e_meta = ent[2:0];
            next_entry();
          end else if (ent[8:3] == 0) begin
            next_entry();
          end else begin
            m_beats = int'(ent[8:3]);
            m_phase = 3;
          end
        end
        3: if (play && beat) begin
          m_beats--;
          if (m_beats == 0) next_entry();
        end
        4: if (!play) m_phase = 0;
        default: m_phase = 0;
      endcase
    end
    e_addr = 7'(m_sreg * 32 + m_idx);
  endtask

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("rom_addr", 32'(rom_addr), 32'(e_addr));
      chk("note_load", 32'(note_load), 32'(e_load));
      chk("note_out", 32'(note_out), 32'(e_note));
      chk("duration_out", 32'(duration_out), 32'(e_dur));
      chk("meta_out", 32'(meta_out), 32'(e_meta));
      chk("song_done", 32'(song_done), 32'(e_done));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    int nl, c0, c1, nbeats, pulses, pcyc;
    logic [2:0] l0, l1, l2;
    logic [5:0] n0, n1;

    for (int i = 0; i < 128; i++) rom[i] = wait_ent(0);
    rom[32] = note_ent(28, 48, 1);
    rom[33] = note_ent(40, 48, 2);
    rom[34] = wait_ent(48);
    rom[64] = wait_ent(5);

    tick(); tick();
    cmp_en = 1'b1;
    chk("reset_addr", 32'(rom_addr), 0);
    chk("reset_load", 32'(note_load), 0);

    // Song 1: two notes then a 48-beat wait; players go busy when loaded.
    reset = 1'b0; song = 2'd1; play = 1'b1;
    nl = 0; c0 = 0; c1 = 0; l0 = 0; l1 = 0; n0 = 0; n1 = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (note_load != 0) begin
        if (nl == 0) begin l0 = note_load; n0 = note_out; c0 = i; end
        if (nl == 1) begin l1 = note_load; n1 = note_out; c1 = i; end
        nl++;
        voice_busy = voice_busy | note_load;
      end
    end
    chk("s1_loads", 32'(nl), 2);
    chk("s1_load0", 32'(l0), 32'b001);
    chk("s1_note0", 32'(n0), 28);
    chk("s1_load1", 32'(l1), 32'b010);
    chk("s1_note1", 32'(n1), 40);
    chk("s1_gap", 32'(c1 - c0), 2);
    chk("s1_wait_addr", 32'(rom_addr), 34);
    nbeats = 0;
    for (int b = 1; b <= 60 && nbeats == 0; b++) begin
      beat = 1'b1; tick(); beat = 1'b0;
      if (rom_addr != 7'd34) nbeats = b;
      tick();
    end
    chk("s1_beats", 32'(nbeats), 48);
    chk("s1_next_addr", 32'(rom_addr), 35);

    // Switch to song 2 (wait 5), then reset mid-wait.
    voice_busy = 3'b000; song = 2'd2;
    tick(); tick(); tick(); tick();
    chk("rst_pre_addr", 32'(rom_addr), 64);
    chk("rst_pre_note", 32'(note_out), 40);
    reset = 1'b1; tick();
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_note", 32'(note_out), 0);
    chk("rst_dur", 32'(duration_out), 0);
    chk("rst_meta", 32'(meta_out), 0);

    // All voices busy: round-robin steal, then a free voice wins.
    play = 1'b0; song = 2'd0;
    rom[0] = note_ent(5, 1, 0); rom[1] = note_ent(6, 2, 0); rom[2] = note_ent(7, 3, 0);
    rom[64] = wait_ent(3); rom[65] = wait_ent(10);
    tick();
    reset = 1'b0; play = 1'b1; voice_busy = 3'b111;
    nl = 0; l0 = 0; l1 = 0; l2 = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (note_load != 0) begin
        if (nl == 0) l0 = note_load;
        if (nl == 1) begin l1 = note_load; voice_busy = 3'b010; end
        if (nl == 2) l2 = note_load;
        nl++;
      end
    end
    chk("rr_loads", 32'(nl), 3);
    chk("rr_first", 32'(l0), 32'b001);
    chk("rr_second", 32'(l1), 32'b010);
    chk("rr_free", 32'(l2), 32'b001);

    // Wait of 3 with a pause in the middle: paused beats do not count.
    voice_busy = 3'b000; song = 2'd2;
    tick(); tick(); tick(); tick();
    chk("pz_addr0", 32'(rom_addr), 64);
    beat = 1'b1; tick(); beat = 1'b0; tick();
    play = 1'b0;
    for (int i = 0; i < 4; i++) begin beat = 1'b1; tick(); beat = 1'b0; tick(); end
    play = 1'b1;
    beat = 1'b1; tick(); beat = 1'b0; tick();
    chk("pz_addr1", 32'(rom_addr), 64);
    beat = 1'b1; tick(); beat = 1'b0;
    chk("pz_addr2", 32'(rom_addr), 65);
    tick(); tick(); tick();

    // Song change during the 10-beat wait; song 3 is 32 zero waits.
    song = 2'd3; tick();
    chk("sw_load", 32'(note_load), 0);
    chk("sw_done", 32'(song_done), 0);
    chk("sw_addr", 32'(rom_addr), 96);
    pulses = 0; pcyc = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (song_done) begin pulses++; if (pcyc == 0) pcyc = i; end
    end
    chk("done_pulses", 32'(pulses), 1);
    chk("done_cycle", 32'(pcyc), 64);
    chk("done_addr", 32'(rom_addr), 127);
    play = 1'b0; tick(); tick();
    chk("idle_addr", 32'(rom_addr), 127);
    chk("idle_done", 32'(song_done), 0);

    // Random traffic against the model; ROM only rewritten under reset.
    for (int r = 0; r < 4; r++) begin
      reset = 1'b1;
      for (int i = 0; i < 128; i++) begin
        if ($urandom_range(0, 9) < 4) rom[i] = wait_ent($urandom_range(0, 3));
        else rom[i] = 16'($urandom) & 16'h7fff;
      end
      tick(); tick();
      reset = 1'b0;
      for (int c = 0; c < 2500; c++) begin
        play = ($urandom_range(0, 9) != 0);
        beat = ($urandom_range(0, 2) == 0);
        voice_busy = 3'($urandom);
        if ($urandom_range(0, 99) == 0) song = 2'($urandom);
        reset = ($urandom_range(0, 399) == 0);
        tick();
      end
    end

    reset = 1'b0;
    cmp_en = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
